mem_stage: RTL and testbench

//  Pipeline stage between EX and WB. Latches the EX result, waits for the data-SRAM

---
 rtl/mem_stage.sv | 189 ++++++++++++++++++
 tb/tb_mem_stage.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MEM pipeline stage. It sits between EX and WB and does the following:
//  - latches the EX result,
//  - waits for the data-SRAM response of an issued request,
//  - aligns and extends load data,
//  - offers the finished instruction to WB over a valid/allowin handshake,
//  - drives the MEM->ID bypass bus.
// After a flush, SRAM responses that belong to killed instructions are counted
// and discarded so they are never taken as the answer for a newer instruction.
module mem_stage #(
    parameter int CANCEL_WIDTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ex_to_mem_valid,
    output logic        mem_allowin,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_result,
    input  logic [2:0]  ex_load_op,
    input  logic        ex_req_sent,
    input  logic        ex_write_en,
    input  logic [4:0]  ex_write_register,
    input  logic [47:0] ex_exception_bus,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    output logic        mem_to_wb_valid,
    input  logic        wb_allowin,
    output logic [31:0] mem_pc,
    output logic        mem_write_en,
    output logic [4:0]  mem_write_register,
    output logic [3:0]  mem_write_strobe,
    output logic [31:0] mem_write_data,
    output logic [47:0] mem_exception_bus,
    input  logic        flush_pipe,
    output logic        mem_to_id_valid,
    output logic        mem_to_id_ready,
    output logic [4:0]  mem_to_id_register,
    output logic [3:0]  mem_to_id_strobe,
    output logic [31:0] mem_to_id_data,
    output logic        mem_cancel_full
);

    localparam logic [CANCEL_WIDTH-1:0] CANCEL_MAX = '1;

    logic                    valid;
    logic                    waiting;
    logic                    buffered;
    logic [CANCEL_WIDTH-1:0] cancel_cnt;
    logic [31:0]             pc_r;
    logic [31:0]             result_r;
    logic [2:0]              load_op_r;
    logic                    write_en_r;
    logic [4:0]              write_register_r;
    logic [47:0]             exception_r;
    logic [31:0]             rdata_buf;

    logic        live_ok;
    logic        ready_go;
    logic        accept;
    logic        capture;
    logic        cnt_inc;
    logic        cnt_dec;
    logic [31:0] rdata_sel;
    logic [31:0] load_data;
    logic [3:0]  load_strobe;

    // Discard counter step: saturating increment, plain decrement.
    function automatic logic [CANCEL_WIDTH-1:0] cancel_next(
        input logic [CANCEL_WIDTH-1:0] cnt,
        input logic                    inc,
        input logic                    dec
    );
        if (inc && !dec)
            return (cnt == CANCEL_MAX) ? cnt : cnt + CANCEL_WIDTH'(1);
        if (dec && !inc)
            return cnt - CANCEL_WIDTH'(1);
        return cnt;
    endfunction

    // A response only belongs to the resident instruction once all stale ones are gone.
    assign live_ok     = data_sram_data_ok && (cancel_cnt == '0);
    assign ready_go    = !waiting || buffered || live_ok;
    assign mem_allowin = !valid || (ready_go && wb_allowin);
    assign accept      = ex_to_mem_valid && mem_allowin && !flush_pipe;
    assign capture     = valid && waiting && !buffered && live_ok && !wb_allowin && !flush_pipe;
    // A flushed instruction still owed a response leaves one stale response in flight.
    assign cnt_inc     = flush_pipe && valid && waiting && !buffered && !live_ok;
    assign cnt_dec     = data_sram_data_ok && (cancel_cnt != '0);

    // Stage occupancy and response-tracking state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid    <= 1'b0;
            waiting  <= 1'b0;
            buffered <= 1'b0;
        end else if (flush_pipe) begin
            valid    <= 1'b0;
            waiting  <= 1'b0;
            buffered <= 1'b0;
        end else if (mem_allowin) begin
            valid    <= ex_to_mem_valid;
            waiting  <= ex_to_mem_valid && ex_req_sent;
            buffered <= 1'b0;
        end else if (capture) begin
            buffered <= 1'b1;
        end
    end

    // Count of SRAM responses still owed to flushed instructions.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            cancel_cnt <= '0;
        else
            cancel_cnt <= cancel_next(cancel_cnt, cnt_inc, cnt_dec);
    end

    // Latch the EX bus when an instruction is accepted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_r             <= '0;
            result_r         <= '0;
            load_op_r        <= '0;
            write_en_r       <= 1'b0;
            write_register_r <= '0;
            exception_r      <= '0;
        end else if (accept) begin
            pc_r             <= ex_pc;
            result_r         <= ex_result;
            load_op_r        <= ex_load_op;
            write_en_r       <= ex_write_en;
            write_register_r <= ex_write_register;
            exception_r      <= ex_exception_bus;
        end
    end

    // Hold read data that arrived while WB was stalled.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            rdata_buf <= '0;
        else if (capture)
            rdata_buf <= data_sram_rdata;
    end

    assign rdata_sel = buffered ? rdata_buf : data_sram_rdata;

    // Align and extend load data by the low address bits; LWL/LWR merge via strobes.
    always_comb begin
        logic [1:0]  a;
        logic [31:0] shifted;
        logic [15:0] half;
        a           = result_r[1:0];
        shifted     = rdata_sel >> {a, 3'b000};
        half        = a[1] ? rdata_sel[31:16] : rdata_sel[15:0];
        load_data   = result_r;
        load_strobe = 4'b1111;
        case (load_op_r)
            3'd1: load_data = rdata_sel;
            3'd2: load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'd3: load_data = {24'd0, shifted[7:0]};
            3'd4: load_data = {{16{half[15]}}, half};
            3'd5: load_data = {16'd0, half};
            3'd6: begin
                load_data   = rdata_sel << {~a, 3'b000};
                load_strobe = 4'b1111 << ~a;
            end
            3'd7: begin
                load_data   = shifted;
                load_strobe = 4'b1111 >> a;
            end
            default: ;
        endcase
    end

    assign mem_to_wb_valid    = valid && ready_go;
    assign mem_pc             = pc_r;
    // Bit 0 of the exception bus is the exception-valid flag.
    assign mem_write_en       = write_en_r && !exception_r[0];
    assign mem_write_register = write_register_r;
    assign mem_write_strobe   = valid ? load_strobe : 4'b0000;
    assign mem_write_data     = load_data;
    assign mem_exception_bus  = exception_r;

    assign mem_to_id_valid    = valid && mem_write_en;
    assign mem_to_id_ready    = valid && ready_go;
    assign mem_to_id_register = write_register_r;
    assign mem_to_id_strobe   = valid ? load_strobe : 4'b0000;
    assign mem_to_id_data     = load_data;
    assign mem_cancel_full    = (cancel_cnt == CANCEL_MAX);

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus randomized traffic. Each cycle is
// checked against a transaction-level model that keeps the SRAM responses in
// flight as a queue tagged live/stale.
module tb_mem_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        ex_to_mem_valid;
    logic        mem_allowin;
    logic [31:0] ex_pc;
    logic [31:0] ex_result;
    logic [2:0]  ex_load_op;
    logic        ex_req_sent;
    logic        ex_write_en;
    logic [4:0]  ex_write_register;
    logic [47:0] ex_exception_bus;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        mem_to_wb_valid;
    logic        wb_allowin;
    logic [31:0] mem_pc;
    logic        mem_write_en;
    logic [4:0]  mem_write_register;
    logic [3:0]  mem_write_strobe;
    logic [31:0] mem_write_data;
    logic [47:0] mem_exception_bus;
    logic        flush_pipe;
    logic        mem_to_id_valid;
    logic        mem_to_id_ready;
    logic [4:0]  mem_to_id_register;
    logic [3:0]  mem_to_id_strobe;
    logic [31:0] mem_to_id_data;
    logic        mem_cancel_full;

    mem_stage #(.CANCEL_WIDTH(2)) dut (
        .clock(clock), .reset(reset),
        .ex_to_mem_valid(ex_to_mem_valid), .mem_allowin(mem_allowin),
        .ex_pc(ex_pc), .ex_result(ex_result), .ex_load_op(ex_load_op),
        .ex_req_sent(ex_req_sent), .ex_write_en(ex_write_en),
        .ex_write_register(ex_write_register), .ex_exception_bus(ex_exception_bus),
        .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
        .mem_to_wb_valid(mem_to_wb_valid), .wb_allowin(wb_allowin),
        .mem_pc(mem_pc), .mem_write_en(mem_write_en),
        .mem_write_register(mem_write_register), .mem_write_strobe(mem_write_strobe),
        .mem_write_data(mem_write_data), .mem_exception_bus(mem_exception_bus),
        .flush_pipe(flush_pipe), .mem_to_id_valid(mem_to_id_valid),
        .mem_to_id_ready(mem_to_id_ready), .mem_to_id_register(mem_to_id_register),
        .mem_to_id_strobe(mem_to_id_strobe), .mem_to_id_data(mem_to_id_data),
        .mem_cancel_full(mem_cancel_full)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct {
        bit        v;
        bit [31:0] pc;
        bit [31:0] res;
        bit [2:0]  op;
        bit        req;
        bit        we;
        bit [4:0]  wr;
        bit [47:0] exc;
        bit        ok;
        bit [31:0] rdata;
        bit        wba;
        bit        fl;
    } stim_t;

    // Reference model: instruction resident in MEM plus the in-flight response queue.
    bit        m_valid, m_needs, m_have;
    bit [31:0] m_pc, m_res, m_buf;
    bit [2:0]  m_op;
    bit        m_we;
    bit [4:0]  m_wr;
    bit [47:0] m_exc;
    bit        q[$];   // one entry per outstanding response, 1 = owner was flushed

    logic [31:0] obs_data;
    logic [3:0]  obs_strb;
    logic        obs_wbv, obs_ready, obs_full;

    function automatic int stale_count();
        int n = 0;
        foreach (q[i]) if (q[i]) n++;
        return n;
    endfunction

    function automatic void ref_align(input bit [2:0] op, input bit [31:0] addr,
                                      input bit [31:0] rd, output bit [31:0] d,
                                      output bit [3:0] s);
        int        a;
        bit [31:0] b;
        a = int'(addr % 4);
        s = 4'hF;
        d = addr;
        case (op)
            3'd1: d = rd;
            3'd2, 3'd3: begin
                b = (rd >> (8 * a)) & 32'hFF;
                d = (op == 3'd2 && b >= 128) ? b + 32'hFFFF_FF00 : b;
            end
            3'd4, 3'd5: begin
                b = (rd >> (16 * (a / 2))) & 32'hFFFF;
                d = (op == 3'd4 && b >= 32768) ? b + 32'hFFFF_0000 : b;
            end
            3'd6: begin
                d = rd << (8 * (3 - a));
                s = 4'((15 << (3 - a)) & 15);
            end
            3'd7: begin
                d = rd >> (8 * a);
                s = 4'(15 >> a);
            end
            default: ;
        endcase
    endfunction

    function automatic stim_t nop();
        stim_t s;
        s = '{default: '0};
        s.wba = 1'b1;
        return s;
    endfunction

    function automatic stim_t ld(input bit [2:0] op, input bit [31:0] addr);
        stim_t s;
        s = nop();
        s.v = 1'b1; s.op = op; s.res = addr; s.req = 1'b1;
        s.we = 1'b1; s.wr = 5'd7; s.pc = 32'h400 + addr;
        return s;
    endfunction

    task automatic drive_idle();
        ex_to_mem_valid = 0; ex_pc = 0; ex_result = 0; ex_load_op = 0; ex_req_sent = 0;
        ex_write_en = 0; ex_write_register = 0; ex_exception_bus = 0;
        data_sram_data_ok = 0; data_sram_rdata = 0; wb_allowin = 1; flush_pipe = 0;
    endtask

    // One cycle: drive, compare at the falling edge, advance the model, pass the rising edge.
    task automatic step(input stim_t s);
        int        sn;
        bit        live_ok, rdy, alw, ewe;
        bit [31:0] rd, ed;
        bit [3:0]  es;
        sn = stale_count();
        if (q.size() == 0) s.ok = 1'b0;
        if (s.v && s.req && sn >= 3) s.v = 1'b0;  // EX honours mem_cancel_full
        ex_to_mem_valid = s.v; ex_pc = s.pc; ex_result = s.res; ex_load_op = s.op;
        ex_req_sent = s.req; ex_write_en = s.we; ex_write_register = s.wr;
        ex_exception_bus = s.exc; data_sram_data_ok = s.ok; data_sram_rdata = s.rdata;
        wb_allowin = s.wba; flush_pipe = s.fl;
        @(negedge clock);
        live_ok = s.ok && (sn == 0);
        rdy = m_valid && (!m_needs || m_have || live_ok);
        alw = !m_valid || (rdy && s.wba);
        ewe = m_we && !m_exc[0];
        rd  = m_have ? m_buf : s.rdata;
        ref_align(m_op, m_res, rd, ed, es);
        obs_data = mem_write_data; obs_strb = mem_write_strobe;
        obs_wbv = mem_to_wb_valid; obs_ready = mem_to_id_ready; obs_full = mem_cancel_full;
        check("allowin", 48'(mem_allowin), 48'(alw));
        check("to_wb_valid", 48'(mem_to_wb_valid), 48'(rdy));
        check("cancel_full", 48'(mem_cancel_full), 48'(sn == 3));
        check("to_id_valid", 48'(mem_to_id_valid), 48'(m_valid && ewe));
        check("to_id_ready", 48'(mem_to_id_ready), 48'(rdy));
        if (rdy) begin
            check("write_data", 48'(mem_write_data), 48'(ed));
            check("write_strobe", 48'(mem_write_strobe), 48'(es));
            check("pc", 48'(mem_pc), 48'(m_pc));
            check("write_en", 48'(mem_write_en), 48'(ewe));
            check("write_reg", 48'(mem_write_register), 48'(m_wr));
            check("exc_bus", mem_exception_bus, m_exc);
            check("id_data", 48'(mem_to_id_data), 48'(ed));
            check("id_strobe", 48'(mem_to_id_strobe), 48'(es));
            check("id_reg", 48'(mem_to_id_register), 48'(m_wr));
        end
        if (s.ok) begin
            void'(q.pop_front());
            if (live_ok && m_valid && !s.fl && !(rdy && s.wba)) begin
                m_have = 1'b1;
                m_buf  = s.rdata;
            end
        end
        if (s.fl) begin
            if (m_valid && m_needs && !m_have && !live_ok && q.size() > 0)
                q[q.size() - 1] = 1'b1;
            m_valid = 1'b0;
        end else if (alw) begin
            m_valid = s.v;
            if (s.v) begin
                m_pc = s.pc; m_res = s.res; m_op = s.op; m_we = s.we;
                m_wr = s.wr; m_exc = s.exc; m_needs = s.req; m_have = 1'b0;
                if (s.req) q.push_back(1'b0);
            end
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        stim_t s;
        drive_idle();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("rst_allowin", 48'(mem_allowin), 48'd1);
        check("rst_wb_valid", 48'(mem_to_wb_valid), 48'd0);
        check("rst_strobe", 48'(mem_write_strobe), 48'd0);
        check("rst_data", 48'(mem_write_data), 48'd0);
        check("rst_id_ready", 48'(mem_to_id_ready), 48'd0);
        check("rst_full", 48'(mem_cancel_full), 48'd0);
        reset = 1'b0;

        // LB from byte 3, response in the first MEM cycle
        step(ld(3'd2, 32'h0000_1003));
        s = nop(); s.ok = 1; s.rdata = 32'h8011_2233; step(s);
        check("lb_valid", 48'(obs_wbv), 48'd1);
        check("lb_data", 48'(obs_data), 48'hFFFF_FF80);
        check("lb_strobe", 48'(obs_strb), 48'hF);

        // LWL at byte 1 and LWR at byte 2
        step(ld(3'd6, 32'h0000_2001));
        s = nop(); s.ok = 1; s.rdata = 32'hAABB_CCDD; step(s);
        check("lwl_data", 48'(obs_data), 48'hCCDD_0000);
        check("lwl_strobe", 48'(obs_strb), 48'hC);
        step(ld(3'd7, 32'h0000_2002));
        s = nop(); s.ok = 1; s.rdata = 32'hAABB_CCDD; step(s);
        check("lwr_data", 48'(obs_data), 48'h0000_AABB);
        check("lwr_strobe", 48'(obs_strb), 48'h3);

        // WB stalled while the response arrives: data held, no re-capture
        step(ld(3'd1, 32'h0000_3000));
        s = nop(); s.ok = 1; s.rdata = 32'h1234_5678; s.wba = 0; step(s);
        for (int i = 0; i < 3; i++) begin
            s = nop(); s.wba = 0; s.rdata = $urandom; step(s);
            check("hold_valid", 48'(obs_wbv), 48'd1);
            check("hold_data", 48'(obs_data), 48'h1234_5678);
        end
        step(nop());

        // Bypass not ready while waiting, ready with aligned data on response
        step(ld(3'd4, 32'h0000_4002));
        step(nop());
        check("wait_ready", 48'(obs_ready), 48'd0);
        s = nop(); s.ok = 1; s.rdata = 32'h8001_0000; step(s);
        check("resp_ready", 48'(obs_ready), 48'd1);
        check("resp_data", 48'(obs_data), 48'hFFFF_8001);

        // Flush a waiting load; the next load must skip the stale response
        step(ld(3'd1, 32'h0000_5000));
        s = ld(3'd3, 32'h0000_5004); s.fl = 1; step(s);
        step(ld(3'd3, 32'h0000_5005));
        s = nop(); s.ok = 1; s.rdata = 32'h1111_1111; step(s);
        check("stale_dropped", 48'(obs_wbv), 48'd0);
        s = nop(); s.ok = 1; s.rdata = 32'h0000_AB00; step(s);
        check("live_valid", 48'(obs_wbv), 48'd1);
        check("live_data", 48'(obs_data), 48'h0000_00AB);

        // Three stale responses saturate the counter, then drain
        for (int i = 0; i < 3; i++) begin
            step(ld(3'd1, 32'h0000_6000 + 32'(4 * i)));
            s = nop(); s.fl = 1; step(s);
        end
        step(nop());
        check("full_set", 48'(obs_full), 48'd1);
        for (int i = 0; i < 3; i++) begin
            s = nop(); s.ok = 1; s.rdata = $urandom; step(s);
        end
        step(nop());
        check("full_clear", 48'(obs_full), 48'd0);

        // Reset while waiting with a saturated counter
        for (int i = 0; i < 3; i++) begin
            step(ld(3'd1, 32'h0000_7000));
            s = nop(); s.fl = 1; step(s);
        end
        step(ld(3'd1, 32'h0000_7100));
        s = ld(3'd1, 32'h0000_7200); s.req = 0; step(s);
        drive_idle();
        reset = 1'b1;
        #1;
        check("mid_rst_valid", 48'(mem_to_wb_valid), 48'd0);
        check("mid_rst_full", 48'(mem_cancel_full), 48'd0);
        check("mid_rst_allowin", 48'(mem_allowin), 48'd1);
        check("mid_rst_id_valid", 48'(mem_to_id_valid), 48'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        q.delete();
        m_valid = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            s = nop();
            s.v     = ($urandom_range(0, 9) < 6);
            s.op    = 3'($urandom_range(0, 7));
            s.req   = (s.op != 3'd0) ? 1'b1 : 1'($urandom_range(0, 1));
            s.pc    = $urandom;
            s.res   = $urandom;
            s.we    = 1'($urandom_range(0, 1));
            s.wr    = 5'($urandom);
            s.exc   = {16'($urandom), 31'($urandom), 1'($urandom_range(0, 7) == 0)};
            s.ok    = ($urandom_range(0, 9) < 4);
            s.rdata = $urandom;
            s.wba   = ($urandom_range(0, 3) != 0);
            s.fl    = ($urandom_range(0, 9) == 0);
            step(s);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
